// File: rtl/lab2_proc_iter_muldiv_unit.sv
// Iterative multiply/divide unit (shift-add multiply, restoring divide) for the TinyRV2 X stage.
// Optional build macro LAB2_PROC_MULDIV_EARLY_EXIT_EN: multiplies leave CALC once the remaining multiplier is zero.
module lab2_proc_iter_muldiv_unit #(
   parameter int NBITS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [2:0]       req_fn,
   input  logic [NBITS-1:0] req_a,
   input  logic [NBITS-1:0] req_b,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic [NBITS-1:0] resp_result
);

   localparam int CW = $clog2(NBITS + 1);
   localparam logic [CW-1:0]    CNT_INIT = CW'(NBITS);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [NBITS-1:0] ZERO     = {NBITS{1'b0}};
   localparam logic [NBITS-1:0] ONES     = {NBITS{1'b1}};
   localparam logic [NBITS-1:0] MIN_VAL  = {1'b1, {(NBITS-1){1'b0}}};

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] FN_MUL   = 3'd0;
   localparam logic [2:0] FN_MULH  = 3'd1;
   localparam logic [2:0] FN_MULHU = 3'd2;
   localparam logic [2:0] FN_DIV   = 3'd3;
   localparam logic [2:0] FN_DIVU  = 3'd4;
   localparam logic [2:0] FN_REM   = 3'd5;
   localparam logic [2:0] FN_REMU  = 3'd6;

   logic [1:0]         state_r;
   logic [2:0]         fn_r;
   logic               neg_r;
   logic [2*NBITS-1:0] a_r;
   logic [NBITS-1:0]   b_r;
   logic [2*NBITS-1:0] acc_r;
   logic [CW-1:0]      cnt_r;
   logic               req_rdy_r;
   logic               resp_val_r;
   logic [NBITS-1:0]   resp_result_r;

   logic               is_signed_s;
   logic [NBITS-1:0]   a_mag_s;
   logic [NBITS-1:0]   b_mag_s;
   logic               neg_s;
   logic               ovf_s;
   logic               b_zero_s;
   logic               special_s;
   logic [NBITS-1:0]   special_res_s;

   // Operand conditioning and special-case resolution at accept
   always_comb begin
      is_signed_s   = (req_fn == FN_MULH) || (req_fn == FN_DIV) || (req_fn == FN_REM);
      a_mag_s       = (is_signed_s && req_a[NBITS-1]) ? -req_a : req_a;
      b_mag_s       = (is_signed_s && req_b[NBITS-1]) ? -req_b : req_b;
      ovf_s         = (req_a == MIN_VAL) && (req_b == ONES);
      b_zero_s      = (req_b == ZERO);
      neg_s         = 1'b0;
      special_s     = 1'b0;
      special_res_s = ZERO;
      case (req_fn)
         FN_MULH: neg_s = req_a[NBITS-1] ^ req_b[NBITS-1];
         FN_DIV: begin
            neg_s = req_a[NBITS-1] ^ req_b[NBITS-1];
            if (b_zero_s) begin
               special_s     = 1'b1;
               special_res_s = ONES;
            end else if (ovf_s) begin
               special_s     = 1'b1;
               special_res_s = MIN_VAL;
            end else begin
               special_s     = 1'b0;
            end
         end
         FN_DIVU: begin
            special_s     = b_zero_s;
            special_res_s = ONES;
         end
         FN_REM: begin
            neg_s = req_a[NBITS-1];
            if (b_zero_s) begin
               special_s     = 1'b1;
               special_res_s = req_a;
            end else if (ovf_s) begin
               special_s     = 1'b1;
               special_res_s = ZERO;
            end else begin
               special_s     = 1'b0;
            end
         end
         FN_REMU: begin
            special_s     = b_zero_s;
            special_res_s = req_a;
         end
         3'd7: special_s = 1'b1;
         default: neg_s = 1'b0;
      endcase
   end

   logic               is_mul_s;
   logic [NBITS:0]     trial_s;
   logic [NBITS-1:0]   diff_s;
   logic               ge_s;
   logic [2*NBITS-1:0] acc_nx_s;
   logic [2*NBITS-1:0] a_nx_s;
   logic [NBITS-1:0]   b_nx_s;
   logic [2*NBITS-1:0] prod_s;
   logic [NBITS-1:0]   q_mag_s;
   logic [NBITS-1:0]   r_mag_s;
   logic [NBITS-1:0]   quo_s;
   logic [NBITS-1:0]   rem_s;
   logic [NBITS-1:0]   result_s;
   logic               early_s;
   logic               last_s;

   // One CALC step: a_r is the shifting multiplicand (mul) or dividend/quotient (div)
   always_comb begin
      is_mul_s = (fn_r == FN_MUL) || (fn_r == FN_MULH) || (fn_r == FN_MULHU);
      trial_s  = {acc_r[NBITS-1:0], a_r[NBITS-1]};
      diff_s   = trial_s[NBITS-1:0] - b_r;
      ge_s     = (trial_s >= {1'b0, b_r});
      if (is_mul_s) begin
         acc_nx_s = acc_r + (b_r[0] ? a_r : {(2*NBITS){1'b0}});
         a_nx_s   = {a_r[2*NBITS-2:0], 1'b0};
         b_nx_s   = {1'b0, b_r[NBITS-1:1]};
      end else begin
         acc_nx_s = {ZERO, (ge_s ? diff_s : trial_s[NBITS-1:0])};
         a_nx_s   = {ZERO, a_r[NBITS-2:0], ge_s};
         b_nx_s   = b_r;
      end
      prod_s  = neg_r ? -acc_nx_s : acc_nx_s;
      q_mag_s = a_nx_s[NBITS-1:0];
      r_mag_s = acc_nx_s[NBITS-1:0];
      quo_s   = neg_r ? -q_mag_s : q_mag_s;
      rem_s   = neg_r ? -r_mag_s : r_mag_s;
      case (fn_r)
         FN_MUL:           result_s = prod_s[NBITS-1:0];
         FN_MULH, FN_MULHU: result_s = prod_s[2*NBITS-1:NBITS];
         FN_DIV, FN_DIVU:  result_s = quo_s;
         FN_REM, FN_REMU:  result_s = rem_s;
         default:          result_s = ZERO;
      endcase
`ifdef LAB2_PROC_MULDIV_EARLY_EXIT_EN
      early_s = is_mul_s && (b_nx_s == ZERO);
`else
      early_s = 1'b0;
`endif
      last_s = (cnt_r == CNT_ONE) || early_s;
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         fn_r          <= 3'd0;
         neg_r         <= 1'b0;
         a_r           <= {(2*NBITS){1'b0}};
         b_r           <= ZERO;
         acc_r         <= {(2*NBITS){1'b0}};
         cnt_r         <= {CW{1'b0}};
         req_rdy_r     <= 1'b1;
         resp_val_r    <= 1'b0;
         resp_result_r <= ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_val && req_rdy_r) begin
                  fn_r      <= req_fn;
                  neg_r     <= neg_s;
                  a_r       <= {ZERO, a_mag_s};
                  b_r       <= b_mag_s;
                  acc_r     <= {(2*NBITS){1'b0}};
                  cnt_r     <= CNT_INIT;
                  req_rdy_r <= 1'b0;
                  if (special_s) begin
                     state_r       <= ST_DONE;
                     resp_val_r    <= 1'b1;
                     resp_result_r <= special_res_s;
                  end else begin
                     state_r <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc_r <= acc_nx_s;
               a_r   <= a_nx_s;
               b_r   <= b_nx_s;
               cnt_r <= cnt_r - CNT_ONE;
               if (last_s) begin
                  state_r       <= ST_DONE;
                  resp_val_r    <= 1'b1;
                  resp_result_r <= result_s;
               end
            end
            ST_DONE: begin
               if (resp_rdy) begin
                  state_r    <= ST_IDLE;
                  resp_val_r <= 1'b0;
                  req_rdy_r  <= 1'b1;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               resp_val_r <= 1'b0;
               req_rdy_r  <= 1'b1;
            end
         endcase
      end
   end

   assign req_rdy     = req_rdy_r;
   assign resp_val    = resp_val_r;
   assign resp_result = resp_result_r;

endmodule
